// File: rtl/lcd_hd44780_sink_if.sv
// LCD write bus: register select, enable strobe and data byte.
// The driver side is the master; the display model is the slave.
interface lcd_hd44780_sink_if;
   logic       lcd_rs;
   logic       lcd_e;
   logic [7:0] lcd_db;

   modport master (output lcd_rs, output lcd_e, output lcd_db);
   modport slave  (input  lcd_rs, input  lcd_e, input  lcd_db);
endinterface

// File: rtl/lcd_hd44780_sink.sv
// Behavioural HD44780-style 20x4 display model, 8-bit bus mode.
// Decodes E-falling-edge strobes into instructions and DDRAM writes and
// exposes the four visible lines plus busy/error status.
module lcd_hd44780_sink #(
   parameter int unsigned BUSY_CYC = 2000,
   parameter int unsigned CLR_CYC  = 82000
) (
   input  logic                ckht,
   input  logic                rst_n,
   lcd_hd44780_sink_if.slave   bus,
   output logic [159:0]        lcd_h0,
   output logic [159:0]        lcd_h1,
   output logic [159:0]        lcd_h2,
   output logic [159:0]        lcd_h3,
   output logic                busy,
   output logic                disp_on,
   output logic                cursor_on,
   output logic                blink_on,
   output logic                timing_err,
   output logic                cmd_err,
   output logic [15:0]         wr_cnt
);

   localparam int unsigned MAX_CYC = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
   localparam int          CNT_W   = $clog2(MAX_CYC + 1);

   // Bus sampled one cycle late so the falling edge of E can be seen
   logic       e_q;
   logic       rs_q;
   logic [7:0] db_q;

   logic [CNT_W-1:0] cnt_reg;
   logic [6:0]       ac_reg;
   logic             id_reg;
   logic             disp_on_reg;
   logic             cursor_on_reg;
   logic             blink_on_reg;
   logic             timing_err_reg;
   logic             cmd_err_reg;
   logic [15:0]      wr_cnt_reg;

   logic             strobe;
   logic             accept;
   logic             is_clr;
   logic             is_home;
   logic             cell_wr;
   logic             cell_clr;
   logic             addr_ok;
   logic [6:0]       wr_idx;
   logic [6:0]       ac_step;
   logic [639:0]     cells_flat;

   // Register the raw bus every cycle
   always_ff @(posedge ckht or negedge rst_n) begin
      if (!rst_n) begin
         e_q  <= 1'b0;
         rs_q <= 1'b0;
         db_q <= 8'h00;
      end else begin
         e_q  <= bus.lcd_e;
         rs_q <= bus.lcd_rs;
         db_q <= bus.lcd_db;
      end
   end

   // Strobe qualification, cell index mapping and address-counter stepping
   always_comb begin
      strobe   = e_q && !bus.lcd_e;
      accept   = strobe && (cnt_reg == '0);
      is_clr   = !rs_q && (db_q == 8'h01);
      is_home  = !rs_q && (db_q[7:1] == 7'b0000001);
      cell_wr  = accept && rs_q;
      cell_clr = accept && is_clr;
      addr_ok  = (db_q[6:0] <= 7'h27) ||
                 ((db_q[6:0] >= 7'h40) && (db_q[6:0] <= 7'h67));
      // DDRAM 0x00-0x27 -> cells 0-39, 0x40-0x67 -> cells 40-79
      wr_idx   = ac_reg[6] ? (7'd40 + {1'b0, ac_reg[5:0]}) : {1'b0, ac_reg[5:0]};
      ac_step  = ac_reg;
      if (id_reg) begin
         case (ac_reg)
            7'h27:   ac_step = 7'h40;
            7'h67:   ac_step = 7'h00;
            default: ac_step = ac_reg + 7'd1;
         endcase
      end else begin
         case (ac_reg)
            7'h40:   ac_step = 7'h27;
            7'h00:   ac_step = 7'h67;
            default: ac_step = ac_reg - 7'd1;
         endcase
      end
   end

   // Busy counter, address counter, display control, error flags, write count
   always_ff @(posedge ckht or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg        <= '0;
         ac_reg         <= 7'h00;
         id_reg         <= 1'b1;
         disp_on_reg    <= 1'b0;
         cursor_on_reg  <= 1'b0;
         blink_on_reg   <= 1'b0;
         timing_err_reg <= 1'b0;
         cmd_err_reg    <= 1'b0;
         wr_cnt_reg     <= 16'h0000;
      end else begin
         // A strobe during busy is dropped and does not reload the counter
         if (strobe && (cnt_reg != '0))
            timing_err_reg <= 1'b1;

         if (accept)
            cnt_reg <= (is_clr || is_home) ? CNT_W'(CLR_CYC) : CNT_W'(BUSY_CYC);
         else if (cnt_reg != '0)
            cnt_reg <= cnt_reg - 1'b1;

         if (accept) begin
            if (rs_q) begin
               if (wr_cnt_reg != 16'hFFFF)
                  wr_cnt_reg <= wr_cnt_reg + 16'd1;
               ac_reg <= ac_step;
            end else if (db_q[7]) begin
               if (addr_ok)
                  ac_reg <= db_q[6:0];
               else
                  cmd_err_reg <= 1'b1;
            end else if (db_q[6]) begin
               cmd_err_reg <= 1'b1;          // CGRAM is not modelled
            end else if (db_q[5]) begin
               if (!db_q[4])
                  cmd_err_reg <= 1'b1;       // only 8-bit bus mode is supported
            end else if (db_q[4]) begin
               cmd_err_reg <= 1'b1;          // shifts are not modelled
            end else if (db_q[3]) begin
               disp_on_reg   <= db_q[2];
               cursor_on_reg <= db_q[1];
               blink_on_reg  <= db_q[0];
            end else if (db_q[2]) begin
               // Display shift is never performed, so S only matters as an error
               id_reg <= db_q[1];
               if (db_q[0])
                  cmd_err_reg <= 1'b1;
            end else if (db_q[1]) begin
               ac_reg <= 7'h00;
            end else if (db_q[0]) begin
               ac_reg <= 7'h00;
               id_reg <= 1'b1;
            end
         end
      end
   end

   // One register per display cell; clear rewrites all 80 in one cycle
   for (genvar gi = 0; gi < 80; gi++) begin : g_cell
      logic [7:0] cell_reg;

      // Cell storage with clear and addressed write
      always_ff @(posedge ckht or negedge rst_n) begin
         if (!rst_n)
            cell_reg <= 8'h20;
         else if (cell_clr)
            cell_reg <= 8'h20;
         else if (cell_wr && (wr_idx == 7'(gi)))
            cell_reg <= db_q;
      end

      assign cells_flat[8*gi +: 8] = cell_reg;
   end

   // Visible lines: column 0 in the top byte of each bus
   for (genvar gi = 0; gi < 20; gi++) begin : g_col
      assign lcd_h0[159-8*gi -: 8] = cells_flat[8*gi       +: 8];
      assign lcd_h2[159-8*gi -: 8] = cells_flat[8*(20+gi)  +: 8];
      assign lcd_h1[159-8*gi -: 8] = cells_flat[8*(40+gi)  +: 8];
      assign lcd_h3[159-8*gi -: 8] = cells_flat[8*(60+gi)  +: 8];
   end

   assign busy       = (cnt_reg != '0);
   assign disp_on    = disp_on_reg;
   assign cursor_on  = cursor_on_reg;
   assign blink_on   = blink_on_reg;
   assign timing_err = timing_err_reg;
   assign cmd_err    = cmd_err_reg;
   assign wr_cnt     = wr_cnt_reg;

endmodule

// File: tb/tb_lcd_hd44780_sink.sv
// Directed bench for the HD44780 display model with shortened busy times.
module tb_lcd_hd44780_sink;
   localparam int unsigned BUSY_CYC = 20;
   localparam int unsigned CLR_CYC  = 200;

   logic          ckht;
   logic          rst_n;
   logic [159:0]  lcd_h0, lcd_h1, lcd_h2, lcd_h3;
   logic          busy, disp_on, cursor_on, blink_on, timing_err, cmd_err;
   logic [15:0]   wr_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   lcd_hd44780_sink_if bus ();

   lcd_hd44780_sink #(.BUSY_CYC(BUSY_CYC), .CLR_CYC(CLR_CYC)) dut (
      .ckht       (ckht),
      .rst_n      (rst_n),
      .bus        (bus),
      .lcd_h0     (lcd_h0),
      .lcd_h1     (lcd_h1),
      .lcd_h2     (lcd_h2),
      .lcd_h3     (lcd_h3),
      .busy       (busy),
      .disp_on    (disp_on),
      .cursor_on  (cursor_on),
      .blink_on   (blink_on),
      .timing_err (timing_err),
      .cmd_err    (cmd_err),
      .wr_cnt     (wr_cnt)
   );

   initial ckht = 1'b0;
   always #5 ckht = ~ckht;

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // One E pulse; results are visible at the negedge this task returns on
   task automatic send(input logic rs, input logic [7:0] db);
      @(negedge ckht);
      bus.lcd_rs = rs;
      bus.lcd_db = db;
      bus.lcd_e  = 1'b1;
      repeat (2) @(negedge ckht);
      bus.lcd_e  = 1'b0;
      @(negedge ckht);
      $display("tx rs=%0d db=%02h busy=%0d wr_cnt=%0d", rs, db, busy, wr_cnt);
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 1000; i++) begin
         if (!busy) break;
         @(negedge ckht);
      end
      if (i == 1000) chk("busy_timeout", 160'(busy), 160'(0));
   endtask

   task automatic send_w(input logic rs, input logic [7:0] db);
      send(rs, db);
      wait_idle();
   endtask

   logic [159:0] sp;
   logic [159:0] str;
   logic [7:0]   ch;

   initial begin
      sp  = {20{8'h20}};
      str = "ABCDEFGHIJKLMNOPQRST";
      bus.lcd_rs = 1'b0;
      bus.lcd_e  = 1'b0;
      bus.lcd_db = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge ckht);
      rst_n = 1'b1;
      @(negedge ckht);

      // 1. reset state
      chk("rst_h0", lcd_h0, sp);
      chk("rst_h1", lcd_h1, sp);
      chk("rst_h2", lcd_h2, sp);
      chk("rst_h3", lcd_h3, sp);
      chk("rst_busy", 160'(busy), 160'(0));
      chk("rst_terr", 160'(timing_err), 160'(0));
      chk("rst_cerr", 160'(cmd_err), 160'(0));
      chk("rst_wrcnt", 160'(wr_cnt), 160'(0));
      chk("rst_disp", 160'(disp_on), 160'(0));

      // 2. init sequence and line 0 fill
      send_w(1'b0, 8'h3C);
      send_w(1'b0, 8'h0C);
      send_w(1'b0, 8'h01);
      send_w(1'b0, 8'h06);
      send(1'b0, 8'h80);
      chk("busy_after_strobe", 160'(busy), 160'(1));
      wait_idle();
      for (int i = 0; i < 20; i++) begin
         ch = str[159-8*i -: 8];
         send_w(1'b1, ch);
      end
      chk("line0_str", lcd_h0, str);
      chk("disp_on", 160'({disp_on, cursor_on, blink_on}), 160'(3'b100));
      chk("wrcnt20", 160'(wr_cnt), 160'(20));
      chk("terr0", 160'(timing_err), 160'(0));
      chk("cerr0", 160'(cmd_err), 160'(0));

      // 3. increment wrap 0x27 -> 0x40
      send_w(1'b0, 8'hA7);
      send_w(1'b1, 8'h31);
      send_w(1'b1, 8'h32);
      chk("cell27", 160'(lcd_h2[7:0]), 160'(8'h31));
      chk("cell40", 160'(lcd_h1[159:152]), 160'(8'h32));

      // 4. decrement mode from 0x67
      send_w(1'b0, 8'hE7);
      send_w(1'b0, 8'h04);
      send_w(1'b1, 8'h58);
      send_w(1'b1, 8'h59);
      chk("cell67", 160'(lcd_h3[7:0]), 160'(8'h58));
      chk("cell66", 160'(lcd_h3[15:8]), 160'(8'h59));
      chk("cerr_e7", 160'(cmd_err), 160'(0));

      // decrement wrap 0x00 -> 0x67
      send_w(1'b0, 8'h80);
      send_w(1'b1, 8'h5A);
      send_w(1'b1, 8'h5B);
      chk("dec_cell00", 160'(lcd_h0[159:152]), 160'(8'h5A));
      chk("dec_wrap67", 160'(lcd_h3[7:0]), 160'(8'h5B));

      // increment wrap 0x67 -> 0x00
      send_w(1'b0, 8'h06);
      send_w(1'b0, 8'hE7);
      send_w(1'b1, 8'h21);
      send_w(1'b1, 8'h22);
      chk("inc_cell67", 160'(lcd_h3[7:0]), 160'(8'h21));
      chk("inc_wrap00", 160'(lcd_h0[159:152]), 160'(8'h22));
      chk("wrcnt28", 160'(wr_cnt), 160'(28));

      // 5. strobe during clear busy time is dropped
      send(1'b0, 8'h01);
      repeat (100) @(negedge ckht);
      send(1'b1, 8'h41);
      chk("busy_clr", 160'(busy), 160'(1));
      chk("terr1", 160'(timing_err), 160'(1));
      chk("clr_h0", lcd_h0, sp);
      chk("clr_h3", lcd_h3, sp);
      chk("wrcnt_drop", 160'(wr_cnt), 160'(28));
      wait_idle();
      send_w(1'b1, 8'h4D);
      chk("clr_ac0", 160'(lcd_h0[159:152]), 160'(8'h4D));

      // 6. invalid DDRAM address leaves AC alone
      send_w(1'b0, 8'hB0);
      chk("cerr_b0", 160'(cmd_err), 160'(1));
      send_w(1'b1, 8'h4E);
      chk("ac_kept", 160'(lcd_h0[159:144]), 160'(16'h4D4E));

      // reset pulse while E is high; the pending strobe must vanish
      @(negedge ckht);
      bus.lcd_rs = 1'b1;
      bus.lcd_db = 8'h55;
      bus.lcd_e  = 1'b1;
      @(negedge ckht);
      rst_n = 1'b0;
      @(negedge ckht);
      bus.lcd_e = 1'b0;
      @(negedge ckht);
      rst_n = 1'b1;
      repeat (3) @(negedge ckht);
      chk("rst2_h0", lcd_h0, sp);
      chk("rst2_h1", lcd_h1, sp);
      chk("rst2_busy", 160'(busy), 160'(0));
      chk("rst2_errs", 160'({timing_err, cmd_err}), 160'(0));
      chk("rst2_wrcnt", 160'(wr_cnt), 160'(0));
      send_w(1'b1, 8'h41);
      send_w(1'b1, 8'h42);
      chk("rst2_ac_id", 160'(lcd_h0[159:144]), 160'(16'h4142));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
